// File: rtl/key_filter_bank_if.sv
`default_nettype none
// ============================================================================
// key_filter_bank_if : key pins in, debounced levels and strobes out
// Rev 1.0
// ============================================================================
interface key_filter_bank_if #(
   parameter int N = 4
);
   logic [N-1:0] key;
   logic [N-1:0] key_level;
   logic [N-1:0] press_pulse;
   logic [N-1:0] release_pulse;
   logic [N-1:0] long_pulse;
   logic         any_pressed;

   modport master (
      output key,
      input  key_level, press_pulse, release_pulse, long_pulse, any_pressed
   );

   modport slave (
      input  key,
      output key_level, press_pulse, release_pulse, long_pulse, any_pressed
   );
endinterface
`default_nettype wire

// File: rtl/key_filter_bank.sv
`default_nettype none
// ============================================================================
// key_filter_bank : N independent active-low key debouncers with long-press
// Rev 1.0
// ============================================================================
module key_filter_bank #(
   parameter int N            = 4,
   parameter int CNT_W        = 18,
   parameter int DEBOUNCE_CYC = 240000,
   parameter int LONG_W       = 24,
   parameter int LONG_CYC     = 12000000,
   parameter int RPT_CYC      = 0
) (
   input  wire logic         clk,
   input  wire logic         rst,
   key_filter_bank_if.slave  bus
);
   localparam logic [CNT_W-1:0]  c_DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [LONG_W-1:0] c_LONG_LAST = LONG_W'(LONG_CYC - 1);
   localparam logic [LONG_W-1:0] c_LC_RELOAD = LONG_W'(LONG_CYC - RPT_CYC);
   localparam bit                c_RPT_ON    = (RPT_CYC != 0);

   logic [N-1:0] w_level;
   logic [N-1:0] w_press;
   logic [N-1:0] w_release;
   logic [N-1:0] w_long;
   logic         r_any;

   generate
      for (genvar i = 0; i < N; i++) begin : g_ch
         logic [1:0]        r_sync;
         logic [CNT_W-1:0]  r_cnt;
         logic [LONG_W-1:0] r_lc;
         logic              r_level;
         logic              r_long_done;
         logic              r_press;
         logic              r_release;
         logic              r_long;
         logic              w_pressed_s;
         logic              w_diff;
         logic              w_commit;

         // Pins are active-low, so the synchronised sample is inverted to
         // compare against the active-high pressed level.
         assign w_pressed_s = ~r_sync[1];
         assign w_diff      = (w_pressed_s != r_level);
         assign w_commit    = w_diff && (r_cnt == c_DEB_LAST);

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_sync      <= 2'b11;
               r_cnt       <= '0;
               r_lc        <= '0;
               r_level     <= 1'b0;
               r_long_done <= 1'b0;
               r_press     <= 1'b0;
               r_release   <= 1'b0;
               r_long      <= 1'b0;
            end else begin
               r_sync    <= {r_sync[0], bus.key[i]};
               r_press   <= 1'b0;
               r_release <= 1'b0;
               r_long    <= 1'b0;

               if (!w_diff) begin
                  r_cnt <= '0;
               end else if (w_commit) begin
                  r_cnt       <= '0;
                  r_level     <= ~r_level;
                  r_press     <= ~r_level;
                  r_release   <= r_level;
                  r_lc        <= '0;
                  r_long_done <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end

               // A commit on this edge owns lc, so a coincident release
               // suppresses the long strobe.
               if (!w_commit && r_level && !r_long_done) begin
                  if (r_lc == c_LONG_LAST) begin
                     r_long <= 1'b1;
                     if (c_RPT_ON) begin
                        r_lc <= c_LC_RELOAD;
                     end else begin
                        r_long_done <= 1'b1;
                     end
                  end else begin
                     r_lc <= r_lc + 1'b1;
                  end
               end
            end
         end

         assign w_level[i]   = r_level;
         assign w_press[i]   = r_press;
         assign w_release[i] = r_release;
         assign w_long[i]    = r_long;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_any <= 1'b0;
      end else begin
         r_any <= |w_level;
      end
   end

   assign bus.key_level     = w_level;
   assign bus.press_pulse   = w_press;
   assign bus.release_pulse = w_release;
   assign bus.long_pulse    = w_long;
   assign bus.any_pressed   = r_any;
endmodule
`default_nettype wire

// File: tb/tb_key_filter_bank.sv
`default_nettype none
// ============================================================================
// tb_key_filter_bank : scoreboard bench for key_filter_bank (repeat and one-shot)
// Rev 1.0
// ============================================================================
module tb_key_filter_bank;
   localparam int K_PRESS = 0;
   localparam int K_REL   = 1;
   localparam int K_LONG  = 2;

   typedef struct {
      int cyc;
      int kind;
      int ch;
      bit b_inst;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   bit   mon_en = 1'b0;
   exp_t sb[$];

   key_filter_bank_if #(.N(2)) bus_a ();
   key_filter_bank_if #(.N(1)) bus_b ();

   key_filter_bank #(
      .N(2), .CNT_W(3), .DEBOUNCE_CYC(4), .LONG_W(4), .LONG_CYC(10), .RPT_CYC(3)
   ) u_dut_a (
      .clk(clk), .rst(rst), .bus(bus_a)
   );

   key_filter_bank #(
      .N(1), .CNT_W(3), .DEBOUNCE_CYC(4), .LONG_W(4), .LONG_CYC(10), .RPT_CYC(0)
   ) u_dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Ordered insert keeps the queue sorted by cycle so the monitor pops the front.
   function automatic void push_exp(input int c, input int kind, input int ch, input bit b_inst);
      exp_t e;
      int   idx;
      e.cyc = c; e.kind = kind; e.ch = ch; e.b_inst = b_inst;
      idx = sb.size();
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].cyc > c) begin
            idx = i;
            break;
         end
      end
      sb.insert(idx, e);
   endfunction

   task automatic at(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         logic [1:0] ep, er, el;
         logic       bp, br, bl;
         exp_t       e;
         ep = '0; er = '0; el = '0; bp = 1'b0; br = 1'b0; bl = 1'b0;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) check("stale_exp", 32'(e.cyc), 32'(cyc));
            if (e.b_inst) begin
               if (e.kind == K_PRESS) bp = 1'b1;
               if (e.kind == K_REL)   br = 1'b1;
               if (e.kind == K_LONG)  bl = 1'b1;
            end else begin
               if (e.kind == K_PRESS) ep[e.ch] = 1'b1;
               if (e.kind == K_REL)   er[e.ch] = 1'b1;
               if (e.kind == K_LONG)  el[e.ch] = 1'b1;
            end
         end
         check("a_press",   32'(bus_a.press_pulse),   32'(ep));
         check("a_release", 32'(bus_a.release_pulse), 32'(er));
         check("a_long",    32'(bus_a.long_pulse),    32'(el));
         check("b_press",   32'(bus_b.press_pulse),   32'(bp));
         check("b_release", 32'(bus_b.release_pulse), 32'(br));
         check("b_long",    32'(bus_b.long_pulse),    32'(bl));
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_lvl"},  32'(bus_a.key_level),     32'h0);
      check({tag, "_prs"},  32'(bus_a.press_pulse),   32'h0);
      check({tag, "_rel"},  32'(bus_a.release_pulse), 32'h0);
      check({tag, "_lng"},  32'(bus_a.long_pulse),    32'h0);
      check({tag, "_any"},  32'(bus_a.any_pressed),   32'h0);
      check({tag, "_blvl"}, 32'(bus_b.key_level),     32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int p;
      bus_a.key = 2'b11;
      bus_b.key = 1'b1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      mon_en = 1'b1;

      // Clean press, repeating long press, release.
      c = cyc + 2;
      at(c);     bus_a.key[0] = 1'b0; push_exp(c + 6, K_PRESS, 0, 1'b0);
      at(c + 5); check("t1_lvl_before", 32'(bus_a.key_level[0]), 32'h0);
      at(c + 6); check("t1_lvl_press",  32'(bus_a.key_level[0]), 32'h1);
                 check("t1_any_lag",    32'(bus_a.any_pressed),  32'h0);
      at(c + 7); check("t1_any",        32'(bus_a.any_pressed),  32'h1);
      p = c + 6;
      push_exp(p + 10, K_LONG, 0, 1'b0);
      push_exp(p + 13, K_LONG, 0, 1'b0);
      push_exp(p + 16, K_LONG, 0, 1'b0);
      at(p + 12); bus_a.key[0] = 1'b1; push_exp(p + 18, K_REL, 0, 1'b0);
      at(p + 18); check("t1_lvl_rel", 32'(bus_a.key_level[0]), 32'h0);
      at(p + 19); check("t1_any_rel", 32'(bus_a.any_pressed),  32'h0);

      // Bounce shorter than the debounce window is rejected.
      c = p + 30;
      at(c);     bus_a.key[0] = 1'b0;
      at(c + 3); bus_a.key[0] = 1'b1;
      at(c + 4); bus_a.key[0] = 1'b0;
      push_exp(c + 10, K_PRESS, 0, 1'b0);
      at(c + 9); check("t2_no_early", 32'(bus_a.key_level[0]), 32'h0);
      p = c + 10;
      push_exp(p + 10, K_LONG, 0, 1'b0);
      at(p + 5); bus_a.key[0] = 1'b1; push_exp(p + 11, K_REL, 0, 1'b0);

      // Release commit on the long edge wins; ch1 runs offset by two cycles.
      c = p + 25;
      at(c); bus_a.key[0] = 1'b0;
      p = c + 6;
      push_exp(p, K_PRESS, 0, 1'b0);
      at(p + 4); bus_a.key[0] = 1'b1; push_exp(p + 10, K_REL, 0, 1'b0);
      at(p + 6); bus_a.key[1] = 1'b0;
      push_exp(p + 12, K_PRESS, 1, 1'b0);
      push_exp(p + 22, K_LONG,  1, 1'b0);
      push_exp(p + 25, K_LONG,  1, 1'b0);
      at(p + 12); check("t5_lvl_ch1", 32'(bus_a.key_level), 32'h2);
      at(p + 21); bus_a.key[1] = 1'b1; push_exp(p + 27, K_REL, 1, 1'b0);

      // One-shot instance: single long strobe over a 40-cycle hold.
      c = p + 40;
      at(c); bus_b.key = 1'b0;
      push_exp(c + 6,  K_PRESS, 0, 1'b1);
      push_exp(c + 16, K_LONG,  0, 1'b1);
      at(c + 40); bus_b.key = 1'b1; push_exp(c + 46, K_REL, 0, 1'b1);

      // Mid-operation reset while held; fresh press after deassert.
      c = c + 60;
      at(c); bus_a.key[0] = 1'b0; push_exp(c + 6, K_PRESS, 0, 1'b0);
      at(c + 7); check("t6_lvl_held", 32'(bus_a.key_level[0]), 32'h1);
      at(c + 8); rst = 1'b0;
      #1 check_all_zero("t6_rst");
      at(c + 10); check_all_zero("t6_rst_hold");
      at(c + 11); rst = 1'b1;
      push_exp(c + 17, K_PRESS, 0, 1'b0);
      push_exp(c + 27, K_LONG,  0, 1'b0);
      at(c + 16); check("t6_lvl_pre", 32'(bus_a.key_level[0]), 32'h0);
      at(c + 23); bus_a.key[0] = 1'b1; push_exp(c + 29, K_REL, 0, 1'b0);

      at(c + 40);
      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
